lc3b_mc_control: RTL and testbench
==================================

Name: lc3b_mc_control

Overview:
Multicycle control FSM for the LC-3b datapath. It sequences fetch, decode and execute for the supported opcode subset. It drives every datapath load enable and mux select, plus the memory read/write handshake. It sits beside the datapath, takes opcode and IR bits and status back from it, and talks directly to the memory port.

Parameters:
MEM_TIMEOUT, 0, if nonzero: cycles to wait for mem_resp before abandoning the access and returning to FETCH1; 0 = wait forever

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  4  IR[15:12], lc3b_opcode encoding
ir5  in  1  IR[5]: immediate flag (ADD/AND), arithmetic flag A (SHF)
ir4  in  1  IR[4]: shift direction D (SHF)
branch_enable  in  1  (IR[11:9] & CC) != 0, from datapath
mem_resp  in  1  memory access complete
load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc  out  1 each  register load enables
pcmux_sel  out  2  0=PC+2, 1=PC+(off9<<1), 2=SR1 (JMP)
storemux_sel  out  1  0=SR1 from IR[8:6], 1=SR1 from IR[11:9]
alumux_sel  out  2  0=SR2, 1=sext(imm5), 2=sext(off6)<<1, 3=imm4
regfilemux_sel  out  2  0=alu_out, 1=MDR, 2=PC+(off9<<1)
marmux_sel  out  1  0=alu_out, 1=PC
mdrmux_sel  out  1  0=alu_out, 1=mem_rdata
aluop  out  4  lc3b_aluop encoding
mem_read, mem_write  out  1 each  memory strobes
mem_byte_enable  out  2  always 2'b11
timeout  out  1  one-cycle pulse when an access is abandoned

Behaviour:
- States: FETCH1, FETCH2, FETCH3, DECODE, S_ADD, S_AND, S_NOT, S_SHF, S_BR, S_BR_TAKEN, S_LEA, S_JMP, S_CALC_ADDR, S_LDR1, S_LDR2, S_STR1, S_STR2.
- Outputs are Moore, decoded from state; aluop also uses ir5/ir4, which are stable IR bits. Any output not listed for a state is 0.
- Reset, rst_n low: state=FETCH1 immediately; all outputs forced 0, mem_byte_enable=2'b11, aluop=alu_add, wait counter=0. On release, the first edge executes FETCH1.
- FETCH1: marmux_sel=1, load_mar, load_pc, pcmux_sel=0 (PC+2). Next: FETCH2.
- FETCH2: mem_read, mdrmux_sel=1, load_mdr. Hold while mem_resp=0. Next: FETCH3 on mem_resp.
- FETCH3: load_ir. Next: DECODE.
- DECODE: no outputs. Next state by opcode: ADD, AND, NOT, SHF, BR, LEA, JMP go to their states; LDR and STR go to S_CALC_ADDR; all other opcodes (JSR, LDB, LDI, STB, STI, TRAP, RTI) go to FETCH1 as a NOP.
- S_ADD / S_AND: aluop=add/and, alumux_sel=ir5, regfilemux_sel=0, load_regfile, load_cc. Next: FETCH1.
- S_NOT: aluop=alu_not, load_regfile, load_cc. Next: FETCH1.
- S_SHF: alumux_sel=3, load_regfile, load_cc. aluop: ir4=0 gives sll; ir4=1,ir5=0 gives srl; ir4=1,ir5=1 gives sra. Next: FETCH1.
- S_BR: no outputs. Next: S_BR_TAKEN if branch_enable, else FETCH1.
- S_BR_TAKEN: pcmux_sel=1, load_pc. Next: FETCH1.
- S_LEA: regfilemux_sel=2, load_regfile, load_cc. Next: FETCH1.
- S_JMP: pcmux_sel=2, load_pc. Next: FETCH1.
- S_CALC_ADDR: alumux_sel=2, aluop=alu_add, marmux_sel=0, load_mar. Next: S_LDR1 for LDR, S_STR1 for STR.
- S_LDR1: mem_read, mdrmux_sel=1, load_mdr. Hold until mem_resp. Next: S_LDR2.
- S_LDR2: regfilemux_sel=1, load_regfile, load_cc. Next: FETCH1.
- S_STR1: storemux_sel=1, aluop=alu_pass, mdrmux_sel=0, load_mdr. Next: S_STR2.
- S_STR2: mem_write. Hold until mem_resp. Next: FETCH1.
- Memory waits:
  - load_mdr stays asserted through every FETCH2/S_LDR1 cycle; MDR's final value is the mem_resp-cycle data.
  - mem_read and mem_write are never both 1.
  - The wait counter clears on entry to each memory state and increments each waiting cycle.
  - If MEM_TIMEOUT!=0 and the count reaches MEM_TIMEOUT-1 with mem_resp still 0, the FSM pulses timeout and goes to FETCH1. PC has already advanced, so the instruction is skipped.
- mem_resp in any non-memory state is ignored.
- Reset asserted mid-access: strobes drop asynchronously and the state returns to FETCH1; a late mem_resp is ignored.

Test Plan:
- ADD R1,R2,#3, mem_resp returned the same cycle as mem_read → FETCH1..S_ADD takes 5 cycles. In S_ADD: alumux_sel=1, aluop=alu_add, load_regfile=1, load_cc=1. Next cycle is FETCH1.
- LDR with a 3-cycle memory latency on both accesses → mem_read high for exactly 3 cycles in FETCH2 and 3 in S_LDR1. Total 11 cycles. S_LDR2 shows regfilemux_sel=1.
- BR with branch_enable=0 → 5 cycles, load_pc never asserted after FETCH1. With branch_enable=1 → 6 cycles, S_BR_TAKEN has pcmux_sel=1, load_pc=1.
- SHF with (ir5,ir4)=00/01/11 → aluop = alu_sll / alu_srl / alu_sra respectively, alumux_sel=3.
- STR, mem_resp withheld with MEM_TIMEOUT=8 → mem_write high 8 cycles, timeout pulses once, state returns to FETCH1. With MEM_TIMEOUT=0 → mem_write held 100+ cycles.
- Drop rst_n during S_LDR1, then a mem_resp pulse → mem_read falls the same cycle, all loads are 0, and on release FETCH1 asserts load_mar=1, marmux_sel=1. The stray mem_resp is ignored. Opcode TRAP → DECODE goes straight to FETCH1.

Source files
------------

// File: rtl/lc3b_mc_control.sv
// lc3b_mc_control: multicycle control FSM for the LC-3b datapath.
// Sequences fetch / decode / execute for BR, ADD, AND, NOT, SHF, LEA, JMP,
// LDR and STR.  Every other opcode is retired as a NOP straight from DECODE.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   opcode, ir5, ir4      IR[15:12], IR[5], IR[4] from the datapath
//   branch_enable         (IR[11:9] & CC) != 0
//   mem_resp              memory access complete
//   load_*                datapath register load enables
//   *_sel, aluop          datapath mux selects and ALU operation
//   mem_read, mem_write   memory strobes (never both high)
//   mem_byte_enable       constant 2'b11 (word accesses only)
//   timeout               one-cycle pulse, in the FETCH1 cycle that follows
//                         an abandoned memory access
//   fsm_state             current state, for debug and checkers
//
// Handshake: a memory access is presented by holding mem_read or mem_write
// high for as long as the FSM sits in FETCH2, S_LDR1 or S_STR2.  The access
// completes in the cycle where mem_resp is sampled high; mem_resp in any
// other state is ignored.  With MEM_TIMEOUT != 0 an access that has seen no
// mem_resp for MEM_TIMEOUT cycles is dropped and the FSM restarts at FETCH1.
module lc3b_mc_control #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       ir5,
  input  logic       ir4,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic [1:0] pcmux_sel,
  output logic       storemux_sel,
  output logic [1:0] alumux_sel,
  output logic [1:0] regfilemux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic [3:0] aluop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable,
  output logic       timeout,
  output logic [4:0] fsm_state
);

  localparam logic [3:0] OP_BR  = 4'h0, OP_ADD = 4'h1, OP_AND = 4'h5,
                         OP_LDR = 4'h6, OP_STR = 4'h7, OP_NOT = 4'h9,
                         OP_JMP = 4'hC, OP_SHF = 4'hD, OP_LEA = 4'hE;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_AND = 4'd1, ALU_NOT = 4'd2,
                         ALU_PASS = 4'd3, ALU_SLL = 4'd4, ALU_SRL = 4'd5,
                         ALU_SRA = 4'd6;

  // Counter only needs to reach MEM_TIMEOUT-1.
  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

  typedef enum logic [4:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    S_ADD, S_AND, S_NOT, S_SHF, S_BR, S_BR_TAKEN, S_LEA, S_JMP,
    S_CALC_ADDR, S_LDR1, S_LDR2, S_STR1, S_STR2
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] wait_cnt;
  logic          timeout_q;
  logic          mem_state, expired, abandon;

  assign mem_state = (state == FETCH2) || (state == S_LDR1) || (state == S_STR2);
  assign expired   = (MEM_TIMEOUT != 0) && (wait_cnt == LAST);
  assign abandon   = mem_state && !mem_resp && expired;

  always_comb begin
    nxt = state;
    case (state)
      FETCH1: nxt = FETCH2;
      FETCH2: begin
        if (mem_resp)     nxt = FETCH3;
        else if (expired) nxt = FETCH1;
      end
      FETCH3: nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_ADD:         nxt = S_ADD;
          OP_AND:         nxt = S_AND;
          OP_NOT:         nxt = S_NOT;
          OP_SHF:         nxt = S_SHF;
          OP_BR:          nxt = S_BR;
          OP_LEA:         nxt = S_LEA;
          OP_JMP:         nxt = S_JMP;
          OP_LDR, OP_STR: nxt = S_CALC_ADDR;
          default:        nxt = FETCH1;
        endcase
      end
      S_BR:        nxt = branch_enable ? S_BR_TAKEN : FETCH1;
      S_CALC_ADDR: nxt = (opcode == OP_STR) ? S_STR1 : S_LDR1;
      S_LDR1: begin
        if (mem_resp)     nxt = S_LDR2;
        else if (expired) nxt = FETCH1;
      end
      S_STR1: nxt = S_STR2;
      S_STR2: begin
        if (mem_resp || expired) nxt = FETCH1;
      end
      default: nxt = FETCH1;
    endcase
  end

  // State, wait counter and the timeout pulse.  Memory states are the only
  // self-loops, so "next == current" means "still waiting".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH1;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= nxt;
      wait_cnt  <= (nxt == state) ? wait_cnt + CW'(1) : '0;
      timeout_q <= abandon;
    end
  end

  // Moore decode.  Gated by rst_n so strobes drop the moment reset asserts.
  always_comb begin
    load_pc        = 1'b0;
    load_ir        = 1'b0;
    load_regfile   = 1'b0;
    load_mar       = 1'b0;
    load_mdr       = 1'b0;
    load_cc        = 1'b0;
    pcmux_sel      = 2'd0;
    storemux_sel   = 1'b0;
    alumux_sel     = 2'd0;
    regfilemux_sel = 2'd0;
    marmux_sel     = 1'b0;
    mdrmux_sel     = 1'b0;
    aluop          = ALU_ADD;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    timeout        = 1'b0;
    if (rst_n) begin
      timeout = timeout_q;
      case (state)
        FETCH1: begin
          marmux_sel = 1'b1;
          load_mar   = 1'b1;
          load_pc    = 1'b1;
        end
        FETCH2, S_LDR1: begin
          mem_read   = 1'b1;
          mdrmux_sel = 1'b1;
          load_mdr   = 1'b1;
        end
        FETCH3: load_ir = 1'b1;
        S_ADD, S_AND: begin
          aluop        = (state == S_AND) ? ALU_AND : ALU_ADD;
          alumux_sel   = {1'b0, ir5};
          load_regfile = 1'b1;
          load_cc      = 1'b1;
        end
        S_NOT: begin
          aluop        = ALU_NOT;
          load_regfile = 1'b1;
          load_cc      = 1'b1;
        end
        S_SHF: begin
          alumux_sel   = 2'd3;
          aluop        = !ir4 ? ALU_SLL : (ir5 ? ALU_SRA : ALU_SRL);
          load_regfile = 1'b1;
          load_cc      = 1'b1;
        end
        S_BR_TAKEN: begin
          pcmux_sel = 2'd1;
          load_pc   = 1'b1;
        end
        S_LEA: begin
          regfilemux_sel = 2'd2;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        S_JMP: begin
          pcmux_sel = 2'd2;
          load_pc   = 1'b1;
        end
        S_CALC_ADDR: begin
          alumux_sel = 2'd2;
          load_mar   = 1'b1;
        end
        S_LDR2: begin
          regfilemux_sel = 2'd1;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        S_STR1: begin
          storemux_sel = 1'b1;
          aluop        = ALU_PASS;
          load_mdr     = 1'b1;
        end
        S_STR2: mem_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_byte_enable = 2'b11;
  assign fsm_state       = state;

endmodule

// File: tb/tb_lc3b_mc_control.sv
// Testbench for lc3b_mc_control.  dut runs with MEM_TIMEOUT=8, dut0 with
// MEM_TIMEOUT=0; both share every input.  Each cycle's expected control word
// and the mem_resp value to drive are queued up front, then drained one
// cycle at a time.
module tb_lc3b_mc_control;
  localparam int W = 22;

  // Control word layout (see obs below).
  localparam logic [W-1:0] B_LD_PC  = W'(1) << 21, B_LD_IR  = W'(1) << 20,
                           B_LD_RF  = W'(1) << 19, B_LD_MAR = W'(1) << 18,
                           B_LD_MDR = W'(1) << 17, B_LD_CC  = W'(1) << 16,
                           B_PC_BR  = W'(1) << 14, B_PC_JMP = W'(2) << 14,
                           B_STORE  = W'(1) << 13,
                           B_ALU_IMM = W'(1) << 11, B_ALU_OFF = W'(2) << 11,
                           B_ALU_IMM4 = W'(3) << 11,
                           B_RF_MDR = W'(1) << 9, B_RF_PCOFF = W'(2) << 9,
                           B_MARMUX = W'(1) << 8, B_MDRMUX = W'(1) << 7,
                           A_AND = W'(1) << 3, A_NOT = W'(2) << 3,
                           A_PASS = W'(3) << 3, A_SLL = W'(4) << 3,
                           A_SRL = W'(5) << 3, A_SRA = W'(6) << 3,
                           B_RD = W'(1) << 2, B_WR = W'(1) << 1, B_TO = W'(1);

  localparam logic [W-1:0] E_F1   = B_LD_PC | B_LD_MAR | B_MARMUX;
  localparam logic [W-1:0] E_F2   = B_RD | B_MDRMUX | B_LD_MDR;
  localparam logic [W-1:0] E_F3   = B_LD_IR;
  localparam logic [W-1:0] E_CALC = B_ALU_OFF | B_LD_MAR;
  localparam logic [W-1:0] E_LDR2 = B_RF_MDR | B_LD_RF | B_LD_CC;
  localparam logic [W-1:0] E_STR1 = B_STORE | A_PASS | B_LD_MDR;
  localparam logic [W-1:0] E_STR2 = B_WR;

  logic clk = 0, rst_n = 0;
  logic [3:0] opcode = 0;
  logic ir5 = 0, ir4 = 0, branch_enable = 0, mem_resp = 0;
  logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic [1:0] pcmux_sel, alumux_sel, regfilemux_sel, mem_byte_enable;
  logic storemux_sel, marmux_sel, mdrmux_sel, mem_read, mem_write, timeout;
  logic [3:0] aluop;
  logic [4:0] fsm_state;
  logic l0_pc, l0_ir, l0_rf, l0_mar, l0_mdr, l0_cc, s0_store, s0_mar, s0_mdr;
  logic rd0, wr0, to0;
  logic [1:0] s0_pc, s0_alu, s0_rf, be0;
  logic [3:0] aluop0;
  logic [4:0] st0;

  logic [W-1:0] obs, obs0, e;
  logic [W-1:0] exp_q[$];
  logic         resp_q[$];
  int n_checks = 0, n_pass = 0;

  assign obs = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
                pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel,
                marmux_sel, mdrmux_sel, aluop, mem_read, mem_write, timeout};
  assign obs0 = {l0_pc, l0_ir, l0_rf, l0_mar, l0_mdr, l0_cc, s0_pc, s0_store,
                 s0_alu, s0_rf, s0_mar, s0_mdr, aluop0, rd0, wr0, to0};

  lc3b_mc_control #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .ir5(ir5), .ir4(ir4),
    .branch_enable(branch_enable), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_cc(load_cc),
    .pcmux_sel(pcmux_sel), .storemux_sel(storemux_sel), .alumux_sel(alumux_sel),
    .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel),
    .mdrmux_sel(mdrmux_sel), .aluop(aluop), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .timeout(timeout), .fsm_state(fsm_state));

  lc3b_mc_control #(.MEM_TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .ir5(ir5), .ir4(ir4),
    .branch_enable(branch_enable), .mem_resp(mem_resp),
    .load_pc(l0_pc), .load_ir(l0_ir), .load_regfile(l0_rf),
    .load_mar(l0_mar), .load_mdr(l0_mdr), .load_cc(l0_cc),
    .pcmux_sel(s0_pc), .storemux_sel(s0_store), .alumux_sel(s0_alu),
    .regfilemux_sel(s0_rf), .marmux_sel(s0_mar), .mdrmux_sel(s0_mdr),
    .aluop(aluop0), .mem_read(rd0), .mem_write(wr0),
    .mem_byte_enable(be0), .timeout(to0), .fsm_state(st0));

  // Clock / reset
  always #5 clk = ~clk;

  // Driver helpers: queue one cycle, or a fetch with the given memory latency.
  task automatic push(input logic [W-1:0] ev, input logic r);
    exp_q.push_back(ev);
    resp_q.push_back(r);
  endtask

  task automatic push_fetch(input int lat);
    push(E_F1, 1'b0);
    for (int i = 1; i <= lat; i++) push(E_F2, i == lat);
    push(E_F3, 1'b0);
    push('0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== '0 || mem_byte_enable !== 2'b11) $display("FAIL reset_outputs: got %h be %b, expected 0 be 11", obs, mem_byte_enable);
    else n_pass++;
    n_checks++;
    if (obs0 !== '0) $display("FAIL reset_outputs_dut0: got %h, expected 0", obs0);
    else n_pass++;
    rst_n = 1;
  endtask

  task automatic test_add;
    opcode = 4'h1; ir5 = 1; ir4 = 0;
    push_fetch(1);
    push(A_SLL & '0 | B_ALU_IMM | B_LD_RF | B_LD_CC, 1'b0);
    while (exp_q.size() != 0) begin
      mem_resp = resp_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL add: got %h expected %h", obs, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    mem_resp = 0;
  endtask

  task automatic test_ldr;
    opcode = 4'h6;
    push_fetch(3);
    push(E_CALC, 1'b0);
    push(E_F2, 1'b0); push(E_F2, 1'b0); push(E_F2, 1'b1);
    push(E_LDR2, 1'b0);
    while (exp_q.size() != 0) begin
      mem_resp = resp_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL ldr: got %h expected %h", obs, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    mem_resp = 0;
  endtask

  task automatic test_br;
    opcode = 4'h0;
    for (int t = 0; t < 2; t++) begin
      branch_enable = (t == 1);
      push_fetch(1);
      push('0, 1'b1);  // stray mem_resp in S_BR must be ignored
      if (t == 1) push(B_PC_BR | B_LD_PC, 1'b0);
      while (exp_q.size() != 0) begin
        mem_resp = resp_q.pop_front();
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL br taken=%0d: got %h expected %h", t, obs, e);
        else n_pass++;
        @(posedge clk); #1;
      end
      mem_resp = 0;
    end
    branch_enable = 0;
  endtask

  task automatic test_shf;
    logic [1:0] mode [3];
    logic [W-1:0] op_e [3];
    mode[0] = 2'b00; mode[1] = 2'b01; mode[2] = 2'b11;
    op_e[0] = A_SLL; op_e[1] = A_SRL; op_e[2] = A_SRA;
    opcode = 4'hD;
    for (int t = 0; t < 3; t++) begin
      {ir5, ir4} = mode[t];
      push_fetch(1);
      push(op_e[t] | B_ALU_IMM4 | B_LD_RF | B_LD_CC, 1'b0);
      while (exp_q.size() != 0) begin
        mem_resp = resp_q.pop_front();
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL shf ir5ir4=%b: got %h expected %h", mode[t], obs, e);
        else n_pass++;
        @(posedge clk); #1;
      end
      mem_resp = 0;
    end
  endtask

  task automatic test_misc;
    logic [3:0] ops [4];
    logic [W-1:0] ex [4];
    ops[0] = 4'h5; ex[0] = A_AND | B_LD_RF | B_LD_CC;       // AND reg form
    ops[1] = 4'h9; ex[1] = A_NOT | B_LD_RF | B_LD_CC;
    ops[2] = 4'hE; ex[2] = B_RF_PCOFF | B_LD_RF | B_LD_CC;
    ops[3] = 4'hC; ex[3] = B_PC_JMP | B_LD_PC;
    ir5 = 0; ir4 = 0;
    for (int t = 0; t < 4; t++) begin
      opcode = ops[t];
      push_fetch($urandom_range(1, 4));
      push(ex[t], 1'b0);
      while (exp_q.size() != 0) begin
        mem_resp = resp_q.pop_front();
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL misc op=%h: got %h expected %h", ops[t], obs, e);
        else n_pass++;
        @(posedge clk); #1;
      end
      mem_resp = 0;
    end
  endtask

  task automatic test_str;
    int l2;
    opcode = 4'h7;
    l2 = $urandom_range(1, 5);
    push_fetch($urandom_range(1, 5));
    push(E_CALC, 1'b0);
    push(E_STR1, 1'b0);
    for (int i = 1; i <= l2; i++) push(E_STR2, i == l2);
    while (exp_q.size() != 0) begin
      mem_resp = resp_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL str: got %h expected %h", obs, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    mem_resp = 0;
  endtask

  task automatic test_trap;
    opcode = 4'hF;
    push_fetch(2);
    push(E_F1, 1'b0);  // DECODE goes straight back to FETCH1
    push(E_F2, 1'b1);
    push(E_F3, 1'b0);
    push('0, 1'b0);
    opcode = 4'hF;
    while (exp_q.size() != 0) begin
      mem_resp = resp_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL trap: got %h expected %h", obs, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    mem_resp = 0;
  endtask

  task automatic test_reset_mid_access;
    opcode = 4'h6;
    push_fetch(1);
    push(E_CALC, 1'b0);
    push(E_F2, 1'b0);
    while (exp_q.size() != 0) begin
      mem_resp = resp_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL mid_reset_pre: got %h expected %h", obs, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    // Still in S_LDR1 here; reset drops the strobes without a clock edge.
    rst_n = 0;
    #1;
    n_checks++;
    if (obs !== '0 || mem_read !== 1'b0) $display("FAIL mid_reset_drop: got %h expected 0", obs);
    else n_pass++;
    mem_resp = 1;
    @(posedge clk); #1;
    n_checks++;
    if (obs !== '0) $display("FAIL mid_reset_hold: got %h expected 0", obs);
    else n_pass++;
    opcode = 4'hF;
    rst_n = 1;
    push(E_F1, 1'b1);  // late mem_resp lands in FETCH1 and is ignored
    push(E_F2, 1'b0);
    push(E_F2, 1'b1);
    push(E_F3, 1'b0);
    push('0, 1'b0);
    while (exp_q.size() != 0) begin
      mem_resp = resp_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL mid_reset_post: got %h expected %h", obs, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    mem_resp = 0;
  endtask

  task automatic test_timeout;
    opcode = 4'h7;
    push_fetch(1);
    push(E_CALC, 1'b0);
    push(E_STR1, 1'b0);
    for (int i = 0; i < 8; i++) push(E_STR2, 1'b0);
    push(E_F1 | B_TO, 1'b0);
    push(E_F2, 1'b0);
    while (exp_q.size() != 0) begin
      mem_resp = resp_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL timeout8: got %h expected %h", obs, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    // MEM_TIMEOUT=0 instance has now waited 10 cycles; it must keep waiting.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== E_STR2) $display("FAIL timeout0_hold cyc=%0d: got %h expected %h", i, obs0, E_STR2);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_ldr;
    test_br;
    test_shf;
    test_misc;
    test_str;
    test_trap;
    test_reset_mid_access;
    test_timeout;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
